bcd_clock_set_ctrl: RTL

Controller that sequences the 12-hour BCD time-of-day counter. In RUN it divides the system clock into a one-cycle ena tick per second. On user request it freezes the counter, lets the user edit hours, minutes and AM/PM with two buttons, then issues a one-cycle load of the new time. It sits between the board push-button synchronisers and the counter's ena/load inputs.

---
 rtl/bcd_clock_set_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/bcd_clock_set_ctrl.sv
// Run/set sequencer for a 12-hour BCD time-of-day counter: issues the 1 Hz ena
// tick in RUN and lets the user edit hours, minutes and AM/PM before a one-cycle load.
module bcd_clock_set_ctrl #(
    parameter int TICK_DIV    = 50000000,
    parameter int SET_TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] cur_hh,
    input  logic [7:0] cur_mm,
    input  logic       cur_pm,
    output logic       ena,
    output logic       load,
    output logic [7:0] load_hh,
    output logic [7:0] load_mm,
    output logic       load_pm,
    output logic       set_hh_act,
    output logic       set_mm_act,
    output logic [1:0] dbg_state
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam int TW = (SET_TIMEOUT > 0) ? $clog2(SET_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((SET_TIMEOUT > 0) ? SET_TIMEOUT - 1 : 0);
    localparam bit TO_EN = (SET_TIMEOUT > 0);

    // dbg_state encoding: 0 RUN, 1 SET_HH, 2 SET_MM, 3 COMMIT
    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_SET_HH = 2'd1,
        S_SET_MM = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d, pre_next;
    logic [TW-1:0] to_q, to_d;
    logic [7:0]    edit_hh_q, edit_hh_d, edit_mm_q, edit_mm_d;
    logic          edit_pm_q, edit_pm_d;
    logic [7:0]    load_hh_q, load_hh_d, load_mm_q, load_mm_d;
    logic          load_pm_q, load_pm_d;
    logic          mode_prev_q, inc_prev_q;
    logic          mode_edge, inc_edge, pre_wrap;

    function automatic logic hh_valid(input logic [7:0] v);
        return ((v[7:4] == 4'd0) && (v[3:0] >= 4'd1) && (v[3:0] <= 4'd9)) ||
               ((v[7:4] == 4'd1) && (v[3:0] <= 4'd2));
    endfunction

    function automatic logic mm_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] hh_step(input logic [7:0] v);
        if (v == 8'h12) return 8'h01;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] mm_step(input logic [7:0] v);
        if (v == 8'h59) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign mode_edge = btn_mode & ~mode_prev_q;
    assign inc_edge  = btn_inc & ~inc_prev_q;
    assign pre_wrap  = (pre_q == PRE_LAST);
    assign pre_next  = pre_wrap ? '0 : pre_q + PW'(1);

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        to_d      = to_q;
        edit_hh_d = edit_hh_q;
        edit_mm_d = edit_mm_q;
        edit_pm_d = edit_pm_q;
        load_hh_d = load_hh_q;
        load_mm_d = load_mm_q;
        load_pm_d = load_pm_q;
        ena       = 1'b0;
        unique case (state_q)
            S_RUN: begin
                to_d = '0;
                // A mode press on the terminal count suppresses that tick.
                if (mode_edge) begin
                    edit_hh_d = hh_valid(cur_hh) ? cur_hh : 8'h12;
                    edit_mm_d = mm_valid(cur_mm) ? cur_mm : 8'h00;
                    edit_pm_d = cur_pm;
                    pre_d     = '0;
                    state_d   = S_SET_HH;
                end else begin
                    ena   = pre_wrap;
                    pre_d = pre_next;
                end
            end
            S_SET_HH, S_SET_MM: begin
                pre_d = pre_next;
                if (mode_edge || inc_edge) to_d = '0;
                if (mode_edge) begin
                    if (state_q == S_SET_HH) begin
                        state_d = S_SET_MM;
                    end else begin
                        load_hh_d = edit_hh_q;
                        load_mm_d = edit_mm_q;
                        load_pm_d = edit_pm_q;
                        state_d   = S_COMMIT;
                    end
                end else if (inc_edge) begin
                    if (state_q == S_SET_HH) begin
                        edit_hh_d = hh_step(edit_hh_q);
                        if (edit_hh_q == 8'h11) edit_pm_d = ~edit_pm_q;
                    end else begin
                        edit_mm_d = mm_step(edit_mm_q);
                    end
                end else if (TO_EN && pre_wrap) begin
                    if (to_q == TO_LAST) begin
                        state_d = S_RUN;
                        pre_d   = '0;
                        to_d    = '0;
                    end else begin
                        to_d = to_q + TW'(1);
                    end
                end
            end
            S_COMMIT: begin
                pre_d   = '0;
                to_d    = '0;
                state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_RUN;
            pre_q       <= '0;
            to_q        <= '0;
            edit_hh_q   <= 8'h12;
            edit_mm_q   <= 8'h00;
            edit_pm_q   <= 1'b0;
            load_hh_q   <= 8'h03;
            load_mm_q   <= 8'h00;
            load_pm_q   <= 1'b1;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            to_q        <= to_d;
            edit_hh_q   <= edit_hh_d;
            edit_mm_q   <= edit_mm_d;
            edit_pm_q   <= edit_pm_d;
            load_hh_q   <= load_hh_d;
            load_mm_q   <= load_mm_d;
            load_pm_q   <= load_pm_d;
            mode_prev_q <= btn_mode;
            inc_prev_q  <= btn_inc;
        end
    end

    assign load       = (state_q == S_COMMIT);
    assign load_hh    = load_hh_q;
    assign load_mm    = load_mm_q;
    assign load_pm    = load_pm_q;
    assign set_hh_act = (state_q == S_SET_HH);
    assign set_mm_act = (state_q == S_SET_MM);
    assign dbg_state  = state_q;

endmodule
